// File: rtl/sram_ctrl_pkg.sv
// Shared types, sizes and helpers for the Wishbone-to-byte-SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle, StSetup, StStrobe, StHold, StAck, StTurnWait
    } state_e;

    localparam int unsigned N_LANES   = 4;
    localparam int unsigned CHIP_BITS = 2;
    localparam int unsigned SRAM_AW   = 21;
    localparam int unsigned WAIT_MIN  = 1;
    localparam int unsigned WAIT_MAX  = 15;
    localparam int unsigned TURN_MAX  = 3;

    // Clamp a wait parameter into range and return the strobe counter's terminal value.
    function automatic logic [3:0] wait_last(input int unsigned w);
        int unsigned c;
        c = (w < WAIT_MIN) ? WAIT_MIN : ((w > WAIT_MAX) ? WAIT_MAX : w);
        return 4'(c - 1);
    endfunction

    // Lowest set bit of a lane mask; lanes are visited in ascending order.
    function automatic logic [1:0] first_lane(input logic [N_LANES-1:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int i = int'(N_LANES) - 1; i >= 0; i--) begin
            if (m[i]) l = 2'(i);
        end
        return l;
    endfunction

endpackage

// File: rtl/sram_byte_cycle.sv
// One SETUP/STROBE/HOLD byte access on the async SRAM; all pin outputs are registered.
module sram_byte_cycle
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_we,
    input  logic [SRAM_AW-1:0]   i_addr,
    input  logic [CHIP_BITS-1:0] i_chip,
    input  logic [7:0]           i_wdata,
    input  logic [7:0]           i_data,
    output logic [N_LANES-1:0]   o_cs_n,
    output logic                 o_read_n,
    output logic                 o_write_n,
    output logic [SRAM_AW-1:0]   o_addr,
    output logic                 o_data_oe,
    output logic [7:0]           o_data_out,
    output logic [7:0]           o_rdata,
    output logic                 o_done
);

    localparam logic [3:0] RdLast = wait_last(RD_WAIT);
    localparam logic [3:0] WrLast = wait_last(WR_WAIT);

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [N_LANES-1:0]   cs_n_q, cs_n_d;
    logic                 read_n_q, read_n_d;
    logic                 write_n_q, write_n_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic                 oe_q, oe_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [7:0]           rdata_q, rdata_d;

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        cs_n_d    = cs_n_q;
        read_n_d  = read_n_q;
        write_n_d = write_n_q;
        addr_d    = addr_q;
        oe_d      = oe_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;

        case (state_q)
            StSetup: begin
                state_d   = StStrobe;
                cnt_d     = 4'd0;
                read_n_d  = we_q;
                write_n_d = ~we_q;
            end
            StStrobe: begin
                if (cnt_q == (we_q ? WrLast : RdLast)) begin
                    state_d   = StHold;
                    read_n_d  = 1'b1;
                    write_n_d = 1'b1;
                    // Sampled on the edge that raises read_n, so the responder's data is still valid.
                    if (!we_q) rdata_d = i_data;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StHold: begin
                state_d = StIdle;
                cs_n_d  = '1;
                oe_d    = 1'b0;
            end
            default: state_d = StIdle;
        endcase

        // A new byte may start from idle or straight out of HOLD with no gap.
        if (i_start && (state_q == StIdle || state_q == StHold)) begin
            state_d = StSetup;
            we_d    = i_we;
            addr_d  = i_addr;
            cs_n_d  = ~(N_LANES'(1) << i_chip);
            oe_d    = i_we;
            wdata_d = i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            we_q      <= 1'b0;
            cnt_q     <= 4'd0;
            cs_n_q    <= '1;
            read_n_q  <= 1'b1;
            write_n_q <= 1'b1;
            addr_q    <= '0;
            oe_q      <= 1'b0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            cs_n_q    <= cs_n_d;
            read_n_q  <= read_n_d;
            write_n_q <= write_n_d;
            addr_q    <= addr_d;
            oe_q      <= oe_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign o_cs_n     = cs_n_q;
    assign o_read_n   = read_n_q;
    assign o_write_n  = write_n_q;
    assign o_addr     = addr_q;
    assign o_data_oe  = oe_q;
    assign o_data_out = wdata_q;
    assign o_rdata    = rdata_q;
    assign o_done     = (state_q == StHold);

endmodule

// File: rtl/sram_wb_ctrl.sv
// Wishbone slave splitting 32-bit accesses into byte cycles on a 4-chip async SRAM bank.
// Define SRAM_BYTE_READ_EN to make reads visit only the lanes selected by sel.
module sram_wb_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 2,
    parameter int unsigned TURN    = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_wb_adr,
    input  logic [3:0]           i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [31:0]          i_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic [31:0]          o_wb_dat,
    output logic                 o_wb_ack,
    output logic [N_LANES-1:0]   o_sram_cs_n,
    output logic                 o_sram_read_n,
    output logic                 o_sram_write_n,
    output logic [SRAM_AW-1:0]   o_sram_addr,
    inout  wire  [7:0]           io_sram_data
);

    localparam int unsigned TurnCyc = (TURN > TURN_MAX) ? TURN_MAX : TURN;

    state_e               state_q, state_d;
    logic                 we_q, we_d;
    logic [SRAM_AW-3:0]   word_q, word_d;
    logic [CHIP_BITS-1:0] chip_q, chip_d;
    logic [31:0]          dat_q, dat_d;
    logic [1:0]           lane_q, lane_d;
    logic [N_LANES-1:0]   mask_q, mask_d;
    logic [31:0]          wb_dat_q, wb_dat_d;
    logic                 ack_q, ack_d;
    logic [1:0]           turn_q, turn_d;

    logic                 start, b_we, byte_done, data_oe;
    logic [1:0]           lane_sel;
    logic [SRAM_AW-3:0]   b_word;
    logic [CHIP_BITS-1:0] b_chip;
    logic [31:0]          b_data;
    logic [SRAM_AW-1:0]   b_addr;
    logic [7:0]           b_wdata, data_out, rdata;
    logic [N_LANES-1:0]   req_mask;
    logic                 unused_adr;

    assign unused_adr = ^{i_wb_adr[31:23], i_wb_adr[1:0]};

`ifdef SRAM_BYTE_READ_EN
    assign req_mask = i_wb_sel;
`else
    assign req_mask = i_wb_we ? i_wb_sel : '1;
`endif

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        word_d   = word_q;
        chip_d   = chip_q;
        dat_d    = dat_q;
        lane_d   = lane_q;
        mask_d   = mask_q;
        wb_dat_d = wb_dat_q;
        ack_d    = ack_q;
        turn_d   = turn_q;
        start    = 1'b0;
        lane_sel = lane_q;
        b_we     = we_q;
        b_word   = word_q;
        b_chip   = chip_q;
        b_data   = dat_q;

        case (state_q)
            StIdle: begin
                if (i_wb_cyc && i_wb_stb) begin
                    we_d   = i_wb_we;
                    word_d = i_wb_adr[20:2];
                    chip_d = i_wb_adr[22:21];
                    dat_d  = i_wb_dat;
                    if (req_mask == '0) begin
                        state_d = StAck;
                        ack_d   = 1'b1;
                    end else begin
                        state_d  = StSetup;
                        start    = 1'b1;
                        lane_sel = first_lane(req_mask);
                        lane_d   = lane_sel;
                        mask_d   = req_mask & ~(N_LANES'(1) << lane_sel);
                        b_we     = i_wb_we;
                        b_word   = i_wb_adr[20:2];
                        b_chip   = i_wb_adr[22:21];
                        b_data   = i_wb_dat;
                    end
                end
            end
            // Byte engine busy; its SETUP/STROBE/HOLD phases live in sram_byte_cycle.
            StSetup: begin
                if (byte_done) begin
                    if (!we_q) wb_dat_d[8*lane_q +: 8] = rdata;
                    if (!i_wb_cyc) begin
                        state_d = StIdle;
                    end else if (mask_q != '0) begin
                        start    = 1'b1;
                        lane_sel = first_lane(mask_q);
                        lane_d   = lane_sel;
                        mask_d   = mask_q & ~(N_LANES'(1) << lane_sel);
                    end else begin
                        state_d = StAck;
                        ack_d   = 1'b1;
                    end
                end
            end
            StAck: begin
                ack_d   = 1'b0;
                turn_d  = 2'd0;
                state_d = (TurnCyc == 0) ? StIdle : StTurnWait;
            end
            StTurnWait: begin
                if (turn_q == 2'(TurnCyc - 1)) state_d = StIdle;
                else turn_d = turn_q + 2'd1;
            end
            default: state_d = StIdle;
        endcase

        b_addr  = {b_word, lane_sel};
        b_wdata = b_data[8*lane_sel +: 8];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            word_q   <= '0;
            chip_q   <= '0;
            dat_q    <= 32'd0;
            lane_q   <= 2'd0;
            mask_q   <= '0;
            wb_dat_q <= 32'd0;
            ack_q    <= 1'b0;
            turn_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            word_q   <= word_d;
            chip_q   <= chip_d;
            dat_q    <= dat_d;
            lane_q   <= lane_d;
            mask_q   <= mask_d;
            wb_dat_q <= wb_dat_d;
            ack_q    <= ack_d;
            turn_q   <= turn_d;
        end
    end

    sram_byte_cycle #(
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) u_byte (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (start),
        .i_we       (b_we),
        .i_addr     (b_addr),
        .i_chip     (b_chip),
        .i_wdata    (b_wdata),
        .i_data     (io_sram_data),
        .o_cs_n     (o_sram_cs_n),
        .o_read_n   (o_sram_read_n),
        .o_write_n  (o_sram_write_n),
        .o_addr     (o_sram_addr),
        .o_data_oe  (data_oe),
        .o_data_out (data_out),
        .o_rdata    (rdata),
        .o_done     (byte_done)
    );

    assign io_sram_data = data_oe ? data_out : 8'hzz;
    assign o_wb_dat     = wb_dat_q;
    assign o_wb_ack     = ack_q;

endmodule

// File: doc/sram_wb_ctrl.md
Name: sram_wb_ctrl

Overview:
- Wishbone slave that turns 32-bit word accesses into byte-wide cycles on the board's asynchronous 2Mx8 SRAM bank: 4 chips, active-low chip selects, 21-bit address, 8-bit bidirectional data.
- It is the initiator end of the SRAM interface. The bench SRAM model is the responder: it drives data while read_n is low and advances that data after read_n rises.
- Sits between the system Wishbone bus and the top-level o_sram_* / io_sram_data pins.

Parameters:
- RD_WAIT, 2, cycles read_n is held low per byte (1..15).
- WR_WAIT, 2, cycles write_n is held low per byte (1..15).
- TURN, 1, idle cycles with all cs_n high between consecutive word accesses (0..3).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_wb_adr  in  32  byte address. [22:21] selects the chip, [20:2] is the word address, [1:0] is ignored.
- i_wb_sel  in  4  byte-lane enables.
- i_wb_we  in  1  write request.
- i_wb_dat  in  32  write data.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- o_wb_dat  out  32  read data.
- o_wb_ack  out  1  one-cycle acknowledge.
- o_sram_cs_n  out  4  one-hot-low chip select.
- o_sram_read_n  out  1  output enable.
- o_sram_write_n  out  1  write enable.
- o_sram_addr  out  21  byte address.
- io_sram_data  inout  8  data bus, driven only during write cycles.

Behaviour:
- Interface: one clock i_clk; reset i_rst is asynchronous and active-high. All outputs are registered.
- Reset values: cs_n=4'hF, read_n=1, write_n=1, addr=0, data bus released (Z), o_wb_dat=0, o_wb_ack=0, FSM=IDLE.
- States: IDLE, SETUP, STROBE, HOLD, ACK, TURN_WAIT.
- IDLE: when cyc&stb are high, latch adr/sel/we/dat and set the lane pointer to the first lane to access.
  - Lanes are accessed in ascending order 0..3. Lane k uses addr={adr[20:2],k[1:0]} and data byte dat[8k+7:8k] (little-endian).
- SETUP (1 cycle): addr and cs_n[adr[22:21]] are valid; read_n and write_n stay high.
  - On writes, io_sram_data is driven with the lane byte from this cycle.
- STROBE (RD_WAIT or WR_WAIT cycles): read_n or write_n is low.
  - Reads capture io_sram_data into byte k of o_wb_dat on the last STROBE cycle, before read_n rises.
- HOLD (1 cycle): strobe is high; addr, cs_n and write data are held. Then:
  - advance to the next lane and return to SETUP; or
  - after the last lane, go to ACK.
- Write lane selection: only lanes with sel=1 are accessed.
- Read lane selection: all 4 lanes are accessed regardless of sel (see optional feature).
- Per-byte latency: RD_WAIT+2 or WR_WAIT+2 cycles. A full read with defaults takes 16 cycles, followed by ACK.
- ACK: o_wb_ack=1 for exactly one cycle, cs_n=4'hF, data bus released. Then TURN_WAIT for TURN cycles (skipped if TURN=0), then IDLE.
  - A new request is never accepted in the ACK cycle.
- Write with sel=4'h0: no SRAM cycle. ACK follows IDLE directly, 1-cycle latency.
- cyc drops mid-access: the current byte completes through HOLD (no truncated strobe), then the FSM goes to IDLE with no ACK; o_wb_dat is left partially updated.
- Reset mid-operation: all outputs take their reset values immediately (asynchronous). The strobe may be truncated; this is accepted.
- read_n and write_n are never low simultaneously.
- The data bus is never driven while read_n is low.

Optional Feature:
- Macro SRAM_BYTE_READ_EN.
- Defined: reads also access only the lanes with sel=1; unselected bytes of o_wb_dat keep their previous value. A read with sel=0 acks after 1 cycle.
- Undefined: reads always access all 4 lanes.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum;
  - N_LANES=4, CHIP_BITS=2, SRAM_AW=21;
  - the wait-parameter limits.
- Sub-module sram_byte_cycle sequences one byte access:
  - inputs: start, we, addr, chip, wdata; outputs: pins, rdata, done;
  - owns SETUP/STROBE/HOLD timing.
- The parent owns Wishbone handshaking, lane selection, ACK and TURN_WAIT.

Test Plan:
- Reset asserted 1 us with bus idle -> cs_n=F, read_n=write_n=1, data bus Z, ack=0; after release, outputs are unchanged until a request arrives.
- Read adr=0x0000_0000, sel=F, bench model returning counter 0,1,2,3 -> four read_n pulses, each 2 cycles low, addr 0..3, cs_n=E; o_wb_dat=0x03020100; ack 17 cycles after stb.
- Write adr=0x0060_0010, dat=0xA1B2C3D4, sel=4'b0101 -> cs_n=7; bytes D4 at addr 0x10 and B2 at addr 0x12; two write_n pulses; data bus stable from SETUP through HOLD; single ack.
- Write sel=0 -> no cs_n activity; ack on the next cycle.
- cyc dropped during lane 1 of a read -> lane 1 completes HOLD; no ack; FSM back to IDLE; a following read succeeds.
- Back-to-back reads with TURN=1 -> at least 1 cycle with cs_n=F between accesses; read_n/write_n overlap never occurs (assertion).
